// File: rtl/sa_psum_deskew.sv
// sa_psum_deskew: re-aligns column-skewed psum outputs of the sa3x3 array into
// whole rows, buffers them in a small FIFO and presents them on valid/ready.
// Optional statistics counters are enabled by defining SA_DESKEW_STATS_EN.
module sa_psum_deskew #(
    parameter int unsigned N     = 3,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ROWS  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic [N-1:0]    col_valid,
    input  logic [N*DW-1:0] psum_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_data,
    output logic            out_last,
    output logic            err_overflow,
    output logic            err_misalign
`ifdef SA_DESKEW_STATS_EN
    ,
    output logic [15:0]     rows_total,
    output logic [7:0]      drop_total
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    // aligned column valids and data
    logic [N-1:0]    av;
    logic [N*DW-1:0] ad;

    // per-column delay lines: column k is delayed by N-1-k stages
    for (genvar k = 0; k < N; k++) begin : g_col
        localparam int unsigned D = N - 1 - k;
        if (D == 0) begin : g_direct
            assign av[k]            = col_valid[k];
            assign ad[k*DW +: DW]   = psum_in[k*DW +: DW];
        end else begin : g_dly
            logic [DW-1:0] sd [D];
            logic [D-1:0]  sv;

            // shift data and valid one stage per clock
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(D); i++) sd[i] <= '0;
                    sv <= '0;
                end else if (clear) begin
                    for (int i = 0; i < int'(D); i++) sd[i] <= '0;
                    sv <= '0;
                end else begin
                    sd[0] <= psum_in[k*DW +: DW];
                    sv[0] <= col_valid[k];
                    for (int i = 1; i < int'(D); i++) begin
                        sd[i] <= sd[i-1];
                        sv[i] <= sv[i-1];
                    end
                end
            end

            assign av[k]          = sv[D-1];
            assign ad[k*DW +: DW] = sd[D-1];
        end
    end

    // FIFO storage and control state
    logic [N*DW-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0] mem_last;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [RW-1:0]   row_cnt;

    logic            all_v;
    logic            mis;
    logic            pop;
    logic            full;
    logic            do_wr;
    logic            ovf;
    logic            wr_last;
    logic [PW-1:0]   rd_ptr_n;
    logic [PW-1:0]   wr_ptr_n;
    logic [CW-1:0]   count_n;
    logic [N*DW-1:0] head_data;
    logic            head_last;

    // write/pop decisions and next head of the FIFO
    always_comb begin
        all_v     = &av;
        mis       = (|av) && !all_v;
        pop       = out_valid && out_ready;
        full      = (count == CW'(DEPTH));
        do_wr     = all_v && (!full || pop);
        ovf       = all_v && full && !pop;
        wr_last   = (row_cnt == RW'(ROWS - 1));
        rd_ptr_n  = pop   ? rd_ptr + PW'(1) : rd_ptr;
        wr_ptr_n  = do_wr ? wr_ptr + PW'(1) : wr_ptr;
        count_n   = count + CW'(do_wr) - CW'(pop);
        head_data = mem_data[rd_ptr_n];
        head_last = mem_last[rd_ptr_n];
        // entry being written this edge becomes the head when the FIFO drains to it
        if (do_wr && (rd_ptr_n == wr_ptr)) begin
            head_data = ad;
            head_last = wr_last;
        end
    end

    // FIFO, row counter, registered outputs and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_data[i] <= '0;
            mem_last     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            row_cnt      <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            err_overflow <= 1'b0;
            err_misalign <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            row_cnt      <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            err_overflow <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            if (do_wr) begin
                mem_data[wr_ptr] <= ad;
                mem_last[wr_ptr] <= wr_last;
                row_cnt          <= wr_last ? '0 : row_cnt + RW'(1);
            end
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            out_valid <= (count_n != '0);
            if (count_n != '0) begin
                out_data <= head_data;
                out_last <= head_last;
            end
            err_overflow <= err_overflow | ovf;
            err_misalign <= err_misalign | mis;
        end
    end

`ifdef SA_DESKEW_STATS_EN
    // written-row and dropped-row statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_total <= '0;
            drop_total <= '0;
        end else if (clear) begin
            rows_total <= '0;
            drop_total <= '0;
        end else begin
            if (do_wr) rows_total <= rows_total + 16'(1);
            if ((ovf || mis) && (drop_total != 8'hFF)) drop_total <= drop_total + 8'(1);
        end
    end
`endif

endmodule

// File: doc/sa_psum_deskew.md
Name: sa_psum_deskew

Overview:
- Output-side companion to the sa3x3 systolic array: the array consumes column-skewed activations and emits column-skewed partial sums.
- This block receives the skewed psum_out columns and re-aligns them into whole result rows.
- It buffers the rows in a small FIFO and presents them downstream on a valid/ready handshake, with row-frame tracking and error flags.

Parameters:
- N, 3, array width; number of psum columns.
- DW, 8, psum width per column.
- DEPTH, 4, output FIFO depth in rows; power of 2, at least 2.
- ROWS, 3, rows per frame; out_last is asserted on the ROWS-th row.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; same meaning as the array's clear.
- col_valid  in  N  bit k = psum column k is valid this cycle.
- psum_in  in  N*DW  column k at bits [k*DW +: DW]; from sa3x3 psum_out1..N.
- out_valid  out  1  aligned row available.
- out_ready  in  1  downstream accepts the row.
- out_data  out  N*DW  aligned row, column k at bits [k*DW +: DW].
- out_last  out  1  qualifies out_data as the last row of a frame.
- err_overflow  out  1  sticky; a row was dropped because the FIFO was full.
- err_misalign  out  1  sticky; aligned column valids disagreed.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following are cleared.
  - Delay lines, FIFO pointers and occupancy, row counter.
  - out_valid=0, out_data=0, out_last=0, err_overflow=0, err_misalign=0.
- Deskew: column k passes through a registered delay line of N-1-k stages, carrying both data and valid. Column N-1 has no delay.
  - A row whose column 0 arrives at edge T is aligned, and its column N-1 is sampled, at edge T+N-1.
- Aligned valid vector av[N]:
  - All bits 1: the row is written to the FIFO at that edge.
  - All bits 0: idle.
  - Mixed: nothing is written and err_misalign sets.
- Latency: the row is at the FIFO head and out_valid=1 in the cycle after the edge that samples column N-1. With an empty FIFO this is 1 cycle.
- Handshake:
  - A pop occurs on an edge where out_valid && out_ready.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - out_valid never drops without a pop.
- FIFO behaviour:
  - Full and write with no pop: the row is dropped and err_overflow sets.
  - Full and write with a pop on the same edge: both happen, and occupancy is unchanged.
  - Empty: out_valid=0 and out_data is held. Write-through to the output in the same cycle is not allowed.
  - Pointers wrap modulo DEPTH.
- Row counter (0..ROWS-1):
  - Stored with each FIFO entry as last = (count==ROWS-1) at write time.
  - Increments on each successful write and wraps to 0 after ROWS-1.
  - Dropped or misaligned rows do not advance it.
- clear:
  - At the next edge it empties the delay lines, the FIFO and the row counter, and clears the sticky flags. out_valid=0 the following cycle.
  - clear has priority over a simultaneous write or pop.
- Arithmetic: none. Data passes bit-exact; no saturation or sign handling.
- Asynchronous reset mid-row discards partial rows. After release, the first full row is counted as row 0.

Optional Feature:
- Macro: SA_DESKEW_STATS_EN.
- When defined:
  - Extra output rows_total (16 bits) counts rows written into the FIFO.
  - Extra output drop_total (8 bits, saturating at 255) counts overflow and misalign drops.
  - Both counters reset on rst_n and on clear.
- When undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Skewed 3x3 result (col0 = 30,42,54 on cycles 1-3; col1 = 42,57,72 on cycles 2-4; col2 = 54,72,90 on cycles 3-5), with out_ready=1:
  - Required rows: {30,42,54}, {42,57,72}, {54,72,90} on consecutive cycles starting at cycle 4.
  - out_last=1 on the third row only; both error flags stay 0.
- Same stimulus with out_ready=0 for 10 cycles, then out_ready=1:
  - out_valid=1 and out_data={30,42,54} held stable throughout the stall.
  - Then 3 pops in order, with no error flags.
- Back-to-back frames of DEPTH+1 rows with out_ready=0:
  - FIFO holds 4 rows and the 5th row is dropped; err_overflow=1.
  - Popped data is the first 4 rows in order.
- Column 1 valid suppressed for one row:
  - err_misalign=1, that row is absent from the output, and the row counter does not advance.
- clear asserted while 2 rows are buffered and 1 row is in flight:
  - out_valid=0 the next cycle; flags are 0.
  - The next full row appears with out_last according to row index 0.
- rst_n pulsed low asynchronously between clock edges mid-frame:
  - Outputs go to 0 immediately, without waiting for an edge.
  - After release, the skewed stimulus from the first scenario reproduces its exact outputs.
